// File: rtl/connect4_turn_ctrl.sv
// connect4_turn_ctrl
// Turn scheduler and arbiter sitting in front of the connect4 game core.
// Only the on-turn player's drop request is forwarded to the core; the other
// player is back-pressured. The core result is returned on a shared response
// channel. An idle turn is forfeited after TIMEOUT_CYCLES cycles (0 disables
// the timer). The starting player alternates between games, and per-player
// wins and ties are counted with saturating counters.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   p0_req_* / p1_req_*             per-player drop request (valid/ready/col)
//   core_op_*                       operation handshake towards the core
//   core_re_*                       result handshake from the core
//   rsp_*                           response to the players (incl. timeout flag)
//   turn                            player currently allowed to move
//   p0_wins, p1_wins, ties          game statistics
//
// state     | meaning
// S_IDLE    | waiting for the on-turn player's request; inactivity timer runs
// S_ISSUE   | latched request presented on the core op handshake
// S_WAIT_RE | waiting for the core result
// S_RSP     | response held until consumed; turn/statistics updated on fire

module connect4_turn_ctrl #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int TO_W           = 16,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             p0_req_valid,
   output logic             p0_req_ready,
   input  logic [2:0]       p0_req_col,
   input  logic             p1_req_valid,
   output logic             p1_req_ready,
   input  logic [2:0]       p1_req_col,
   input  logic             core_op_ready,
   output logic             core_op_valid,
   output logic             core_op_player_id,
   output logic [2:0]       core_op_col_id,
   output logic             core_re_ready,
   input  logic             core_re_valid,
   input  logic             core_re_err,
   input  logic             core_re_is_finished,
   input  logic             core_re_winner,
   input  logic             core_re_tie,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_player,
   output logic             rsp_err,
   output logic             rsp_finished,
   output logic             rsp_winner,
   output logic             rsp_tie,
   output logic             rsp_timeout,
   output logic             turn,
   output logic [CNT_W-1:0] p0_wins,
   output logic [CNT_W-1:0] p1_wins,
   output logic [CNT_W-1:0] ties
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RE, S_RSP} state_t;

   // Inactivity timer is a down-counter reloaded on every entry to S_IDLE;
   // reaching zero in S_IDLE marks the last allowed idle cycle.
   localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [TO_W-1:0] TO_LOAD = TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state_q, state_d;
   logic              turn_q, turn_d;
   logic              start_q, start_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              op_valid_q, op_valid_d;
   logic              op_player_q, op_player_d;
   logic [2:0]        op_col_q, op_col_d;
   logic              re_ready_q, re_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_player_q, rsp_player_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_fin_q, rsp_fin_d;
   logic              rsp_win_q, rsp_win_d;
   logic              rsp_tie_q, rsp_tie_d;
   logic              rsp_to_q, rsp_to_d;
   logic [CNT_W-1:0]  p0_wins_q, p0_wins_d;
   logic [CNT_W-1:0]  p1_wins_q, p1_wins_d;
   logic [CNT_W-1:0]  ties_q, ties_d;
   logic              req_fire;

   assign p0_req_ready = (state_q == S_IDLE) && !turn_q;
   assign p1_req_ready = (state_q == S_IDLE) &&  turn_q;
   assign req_fire     = (p0_req_valid && p0_req_ready) || (p1_req_valid && p1_req_ready);

   always_comb begin
      state_d      = state_q;
      turn_d       = turn_q;
      start_d      = start_q;
      to_cnt_d     = to_cnt_q;
      op_valid_d   = op_valid_q;
      op_player_d  = op_player_q;
      op_col_d     = op_col_q;
      re_ready_d   = re_ready_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_player_d = rsp_player_q;
      rsp_err_d    = rsp_err_q;
      rsp_fin_d    = rsp_fin_q;
      rsp_win_d    = rsp_win_q;
      rsp_tie_d    = rsp_tie_q;
      rsp_to_d     = rsp_to_q;
      p0_wins_d    = p0_wins_q;
      p1_wins_d    = p1_wins_q;
      ties_d       = ties_q;

      case (state_q)
         S_IDLE: begin
            // a request arriving on the last idle cycle still wins over the forfeit
            if (req_fire) begin
               op_valid_d  = 1'b1;
               op_player_d = turn_q;
               op_col_d    = turn_q ? p1_req_col : p0_req_col;
               state_d     = S_ISSUE;
            end else if (TO_EN && (to_cnt_q == '0)) begin
               rsp_valid_d  = 1'b1;
               rsp_to_d     = 1'b1;
               rsp_player_d = turn_q;
               rsp_err_d    = 1'b0;
               rsp_fin_d    = 1'b0;
               rsp_win_d    = 1'b0;
               rsp_tie_d    = 1'b0;
               state_d      = S_RSP;
            end else if (TO_EN) begin
               to_cnt_d = to_cnt_q - TO_W'(1);
            end
         end
         S_ISSUE: begin
            if (op_valid_q && core_op_ready) begin
               op_valid_d = 1'b0;
               re_ready_d = 1'b1;
               state_d    = S_WAIT_RE;
            end
         end
         S_WAIT_RE: begin
            if (core_re_valid && re_ready_q) begin
               re_ready_d   = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_to_d     = 1'b0;
               rsp_player_d = op_player_q;
               rsp_err_d    = core_re_err;
               rsp_fin_d    = core_re_is_finished;
               rsp_win_d    = core_re_winner;
               rsp_tie_d    = core_re_tie;
               state_d      = S_RSP;
            end
         end
         S_RSP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               to_cnt_d    = TO_LOAD;
               state_d     = S_IDLE;
               if (rsp_to_q) begin
                  turn_d = ~turn_q;
               end else if (rsp_err_q) begin
                  turn_d = turn_q;
               end else if (rsp_fin_q) begin
                  if (rsp_tie_q) begin
                     if (ties_q != CNT_MAX) ties_d = ties_q + CNT_W'(1);
                  end else if (rsp_win_q) begin
                     if (p1_wins_q != CNT_MAX) p1_wins_d = p1_wins_q + CNT_W'(1);
                  end else begin
                     if (p0_wins_q != CNT_MAX) p0_wins_d = p0_wins_q + CNT_W'(1);
                  end
                  // the other player opens the next game
                  start_d = ~start_q;
                  turn_d  = ~start_q;
               end else begin
                  turn_d = ~turn_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         turn_q       <= 1'b0;
         start_q      <= 1'b0;
         to_cnt_q     <= TO_LOAD;
         op_valid_q   <= 1'b0;
         op_player_q  <= 1'b0;
         op_col_q     <= '0;
         re_ready_q   <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_player_q <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_fin_q    <= 1'b0;
         rsp_win_q    <= 1'b0;
         rsp_tie_q    <= 1'b0;
         rsp_to_q     <= 1'b0;
         p0_wins_q    <= '0;
         p1_wins_q    <= '0;
         ties_q       <= '0;
      end else begin
         state_q      <= state_d;
         turn_q       <= turn_d;
         start_q      <= start_d;
         to_cnt_q     <= to_cnt_d;
         op_valid_q   <= op_valid_d;
         op_player_q  <= op_player_d;
         op_col_q     <= op_col_d;
         re_ready_q   <= re_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_player_q <= rsp_player_d;
         rsp_err_q    <= rsp_err_d;
         rsp_fin_q    <= rsp_fin_d;
         rsp_win_q    <= rsp_win_d;
         rsp_tie_q    <= rsp_tie_d;
         rsp_to_q     <= rsp_to_d;
         p0_wins_q    <= p0_wins_d;
         p1_wins_q    <= p1_wins_d;
         ties_q       <= ties_d;
      end
   end

   assign core_op_valid     = op_valid_q;
   assign core_op_player_id = op_player_q;
   assign core_op_col_id    = op_col_q;
   assign core_re_ready     = re_ready_q;
   assign rsp_valid         = rsp_valid_q;
   assign rsp_player        = rsp_player_q;
   assign rsp_err           = rsp_err_q;
   assign rsp_finished      = rsp_fin_q;
   assign rsp_winner        = rsp_win_q;
   assign rsp_tie           = rsp_tie_q;
   assign rsp_timeout       = rsp_to_q;
   assign turn              = turn_q;
   assign p0_wins           = p0_wins_q;
   assign p1_wins           = p1_wins_q;
   assign ties              = ties_q;

endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// Testbench for connect4_turn_ctrl. The bench plays the role of the game core
// (either a real board model or random results) and keeps a game-level model
// of turn order, starting player and saturating statistics.

module tb_connect4_turn_ctrl;
   localparam int TIMEOUT_CYCLES = 20;
   localparam int TO_W           = 16;
   localparam int CNT_W          = 2;
   localparam int CNT_MAX        = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             p0_req_valid, p0_req_ready;
   logic [2:0]       p0_req_col;
   logic             p1_req_valid, p1_req_ready;
   logic [2:0]       p1_req_col;
   logic             core_op_ready, core_op_valid, core_op_player_id;
   logic [2:0]       core_op_col_id;
   logic             core_re_ready, core_re_valid, core_re_err, core_re_is_finished;
   logic             core_re_winner, core_re_tie;
   logic             rsp_valid, rsp_ready, rsp_player, rsp_err, rsp_finished;
   logic             rsp_winner, rsp_tie, rsp_timeout, turn;
   logic [CNT_W-1:0] p0_wins, p1_wins, ties;

   int vectors = 0;
   int miscompares = 0;

   // game-level reference model
   int m_turn, m_start, m_p0w, m_p1w, m_ties;
   // core emulation
   int grid[7][6];
   int hgt[7];
   int moves;
   bit use_board;
   logic res_err, res_fin, res_win, res_tie;
   logic [6:0] last_rsp;

   always #5 clk = ~clk;

   connect4_turn_ctrl #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_col(p0_req_col),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_col(p1_req_col),
      .core_op_ready(core_op_ready), .core_op_valid(core_op_valid),
      .core_op_player_id(core_op_player_id), .core_op_col_id(core_op_col_id),
      .core_re_ready(core_re_ready), .core_re_valid(core_re_valid),
      .core_re_err(core_re_err), .core_re_is_finished(core_re_is_finished),
      .core_re_winner(core_re_winner), .core_re_tie(core_re_tie),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_player(rsp_player),
      .rsp_err(rsp_err), .rsp_finished(rsp_finished), .rsp_winner(rsp_winner),
      .rsp_tie(rsp_tie), .rsp_timeout(rsp_timeout), .turn(turn),
      .p0_wins(p0_wins), .p1_wins(p1_wins), .ties(ties)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic board_clear();
      for (int c = 0; c < 7; c++) begin
         hgt[c] = 0;
         for (int r = 0; r < 6; r++) grid[c][r] = -1;
      end
      moves = 0;
   endtask

   function automatic int run_len(int c, int r, int dc, int dr, int p);
      int n = 0;
      int cc = c + dc;
      int rr = r + dr;
      while (cc >= 0 && cc < 7 && rr >= 0 && rr < 6 && grid[cc][rr] == p) begin
         n++;
         cc += dc;
         rr += dr;
      end
      return n;
   endfunction

   task automatic board_drop(input int p, input int c);
      int r, best, len;
      res_err = 0; res_fin = 0; res_win = 0; res_tie = 0;
      if (c > 6 || hgt[c] >= 6) begin
         res_err = 1;
         return;
      end
      r = hgt[c];
      grid[c][r] = p;
      hgt[c]++;
      moves++;
      best = 1 + run_len(c, r, 1, 0, p) + run_len(c, r, -1, 0, p);
      len  = 1 + run_len(c, r, 0, 1, p) + run_len(c, r, 0, -1, p);
      if (len > best) best = len;
      len  = 1 + run_len(c, r, 1, 1, p) + run_len(c, r, -1, -1, p);
      if (len > best) best = len;
      len  = 1 + run_len(c, r, 1, -1, p) + run_len(c, r, -1, 1, p);
      if (len > best) best = len;
      if (best >= 4) begin
         res_fin = 1; res_win = 1'(p);
      end else if (moves == 42) begin
         res_fin = 1; res_tie = 1;
      end
      if (res_fin) board_clear();
   endtask

   task automatic random_result(input int p);
      int k;
      k = $urandom_range(0, 9);
      res_err = 0; res_fin = 0; res_win = 0; res_tie = 0;
      if (k < 2) res_err = 1;
      else if (k == 2) begin res_fin = 1; res_win = 1'(p); end
      else if (k == 3) begin res_fin = 1; res_tie = 1; end
   endtask

   // Game rules: forfeit or normal move passes the turn, an error lets the same
   // player retry, a finished game credits the result and the other player
   // opens the next game.
   task automatic model_resolve(input bit to, input bit err, input bit fin, input bit win, input bit tie);
      if (to) m_turn = 1 - m_turn;
      else if (err) begin end
      else if (fin) begin
         if (tie) m_ties = (m_ties < CNT_MAX) ? m_ties + 1 : m_ties;
         else if (win) m_p1w = (m_p1w < CNT_MAX) ? m_p1w + 1 : m_p1w;
         else m_p0w = (m_p0w < CNT_MAX) ? m_p0w + 1 : m_p0w;
         m_start = 1 - m_start;
         m_turn  = m_start;
      end else m_turn = 1 - m_turn;
   endtask

   task automatic model_reset();
      m_turn = 0; m_start = 0; m_p0w = 0; m_p1w = 0; m_ties = 0;
      board_clear();
   endtask

   task automatic set_req(input int p, input bit v, input logic [2:0] c);
      if (p == 0) begin p0_req_valid = v; p0_req_col = c; end
      else begin p1_req_valid = v; p1_req_col = c; end
   endtask

   task automatic drive_idle();
      set_req(0, 0, 3'd0);
      set_req(1, 0, 3'd0);
      core_op_ready = 0; core_re_valid = 0;
      core_re_err = 0; core_re_is_finished = 0; core_re_winner = 0; core_re_tie = 0;
      rsp_ready = 0;
   endtask

   task automatic apply_reset();
      rst_n = 0;
      drive_idle();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      model_reset();
   endtask

   // One full move: request, core op, core result, response. Entered and left
   // 1 time unit after a rising edge with the controller idle.
   task automatic transact(input int p, input logic [2:0] col, input int idle_d,
                           input int op_stall, input int re_lat, input int rsp_stall, input bit noise);
      logic [1:0] rdy;
      logic [6:0] exp;
      repeat (idle_d) begin @(posedge clk); #1; end
      if (noise) set_req(1 - p, 1, 3'($urandom_range(0, 7)));
      set_req(p, 1, col);
      rdy = (p == 0) ? {p0_req_ready, p1_req_ready} : {p1_req_ready, p0_req_ready};
      vectors++;
      if (rdy !== 2'b10) begin
         miscompares++;
         $display("FAIL req_ready p%0d: got own/other=%b expected 10", p, rdy);
      end
      @(posedge clk); #1;
      set_req(0, 0, 3'd0);
      set_req(1, 0, 3'd0);
      for (int i = 0; i <= op_stall; i++) begin
         vectors++;
         if ({core_op_valid, core_op_player_id, core_op_col_id} !== {1'b1, 1'(p), col}) begin
            miscompares++;
            $display("FAIL op_payload: got v=%b id=%b col=%0d expected v=1 id=%0d col=%0d",
                     core_op_valid, core_op_player_id, core_op_col_id, p, col);
         end
         if (i == op_stall) core_op_ready = 1;
         @(posedge clk); #1;
      end
      core_op_ready = 0;
      if (use_board) board_drop(p, int'(col));
      else random_result(p);
      for (int i = 0; i <= re_lat; i++) begin
         vectors++;
         if ({core_re_ready, core_op_valid, rsp_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL re_wait: got re_ready/op_valid/rsp_valid=%b expected 100",
                     {core_re_ready, core_op_valid, rsp_valid});
         end
         if (i == re_lat) begin
            core_re_valid = 1; core_re_err = res_err; core_re_is_finished = res_fin;
            core_re_winner = res_win; core_re_tie = res_tie;
         end
         @(posedge clk); #1;
      end
      core_re_valid = 0;
      {core_re_err, core_re_is_finished, core_re_winner, core_re_tie} = 4'($urandom_range(0, 15));
      exp = {1'b1, 1'(p), res_err, res_fin, res_win, res_tie, 1'b0};
      last_rsp = {rsp_valid, rsp_player, rsp_err, rsp_finished, rsp_winner, rsp_tie, rsp_timeout};
      for (int i = 0; i <= rsp_stall; i++) begin
         vectors++;
         if ({rsp_valid, rsp_player, rsp_err, rsp_finished, rsp_winner, rsp_tie, rsp_timeout, core_re_ready} !== {exp, 1'b0}) begin
            miscompares++;
            $display("FAIL rsp_fields cycle %0d: got v/pl/err/fin/win/tie/to/re_rdy=%b expected %b",
                     i, {rsp_valid, rsp_player, rsp_err, rsp_finished, rsp_winner, rsp_tie, rsp_timeout, core_re_ready}, {exp, 1'b0});
         end
         if (i == rsp_stall) rsp_ready = 1;
         @(posedge clk); #1;
      end
      rsp_ready = 0;
      model_resolve(0, res_err, res_fin, res_win, res_tie);
      vectors++;
      if ({rsp_valid, turn, p0_wins, p1_wins, ties} !== {1'b0, 1'(m_turn), CNT_W'(m_p0w), CNT_W'(m_p1w), CNT_W'(m_ties)}) begin
         miscompares++;
         $display("FAIL post_move: got rsp_valid=%b turn=%b p0w=%0d p1w=%0d ties=%0d expected 0 %0d %0d %0d %0d",
                  rsp_valid, turn, p0_wins, p1_wins, ties, m_turn, m_p0w, m_p1w, m_ties);
      end
   endtask

   // Stay idle from the moment S_IDLE was entered and expect the forfeit.
   task automatic expect_timeout(input int rsp_stall);
      int n = 0;
      logic [6:0] exp;
      while (rsp_valid !== 1'b1 && n < 2 * TIMEOUT_CYCLES) begin
         @(posedge clk); #1;
         n++;
      end
      vectors++;
      if (n !== TIMEOUT_CYCLES) begin
         miscompares++;
         $display("FAIL timeout_delay: got %0d cycles expected %0d", n, TIMEOUT_CYCLES);
      end
      exp = {1'b1, 1'(m_turn), 5'b00001};
      for (int i = 0; i <= rsp_stall; i++) begin
         vectors++;
         if ({rsp_valid, rsp_player, rsp_err, rsp_finished, rsp_winner, rsp_tie, rsp_timeout} !== exp) begin
            miscompares++;
            $display("FAIL timeout_rsp: got %b expected %b",
                     {rsp_valid, rsp_player, rsp_err, rsp_finished, rsp_winner, rsp_tie, rsp_timeout}, exp);
         end
         if (i == rsp_stall) rsp_ready = 1;
         @(posedge clk); #1;
      end
      rsp_ready = 0;
      model_resolve(1, 0, 0, 0, 0);
      vectors++;
      if ({rsp_valid, turn} !== {1'b0, 1'(m_turn)}) begin
         miscompares++;
         $display("FAIL timeout_turn: got rsp_valid=%b turn=%b expected 0 %0d", rsp_valid, turn, m_turn);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++;
      if ({core_op_valid, core_op_player_id, core_op_col_id, core_re_ready, rsp_valid, rsp_player, rsp_err,
           rsp_finished, rsp_winner, rsp_tie, rsp_timeout, turn, p0_wins, p1_wins, ties} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got nonzero %b", {core_op_valid, core_op_col_id, core_re_ready, rsp_valid,
                  rsp_player, rsp_err, rsp_finished, rsp_winner, rsp_tie, rsp_timeout, turn, p0_wins, p1_wins, ties});
      end
      vectors++;
      if ({p0_req_ready, p1_req_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL reset_ready: got %b expected 10", {p0_req_ready, p1_req_ready});
      end
      // abandon an operation that the core has not accepted yet
      set_req(0, 1, 3'd5);
      @(posedge clk); #1;
      set_req(0, 0, 3'd0);
      vectors++;
      if ({core_op_valid, core_op_col_id} !== 4'b1101) begin
         miscompares++;
         $display("FAIL midop_issue: got v=%b col=%0d expected v=1 col=5", core_op_valid, core_op_col_id);
      end
      #2 rst_n = 0;
      #1;
      vectors++;
      if ({core_op_valid, core_op_col_id, core_re_ready, rsp_valid, turn, p0_req_ready} !== 8'b0000_0001) begin
         miscompares++;
         $display("FAIL async_reset: got op_v/col/re_rdy/rsp_v/turn/p0_rdy=%b expected 00000001",
                  {core_op_valid, core_op_col_id, core_re_ready, rsp_valid, turn, p0_req_ready});
      end
      @(posedge clk); #1 rst_n = 1;
      model_reset();
   endtask

   task automatic test_offturn_timeout();
      int first = -1;
      apply_reset();
      set_req(1, 1, 3'd4);
      for (int i = 1; i <= 50; i++) begin
         @(posedge clk); #1;
         vectors++;
         if ({p1_req_ready, core_op_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL offturn_blocked cycle %0d: got p1_ready/op_valid=%b expected 00", i, {p1_req_ready, core_op_valid});
         end
         if (rsp_valid === 1'b1 && first < 0) first = i;
      end
      vectors++;
      if (first !== TIMEOUT_CYCLES) begin
         miscompares++;
         $display("FAIL offturn_timeout_at: got cycle %0d expected %0d", first, TIMEOUT_CYCLES);
      end
      vectors++;
      if ({rsp_valid, rsp_player, rsp_err, rsp_finished, rsp_winner, rsp_tie, rsp_timeout} !== 7'b1000001) begin
         miscompares++;
         $display("FAIL offturn_rsp: got %b expected 1000001",
                  {rsp_valid, rsp_player, rsp_err, rsp_finished, rsp_winner, rsp_tie, rsp_timeout});
      end
      set_req(1, 0, 3'd0);
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      model_resolve(1, 0, 0, 0, 0);
      vectors++;
      if ({rsp_valid, turn} !== 2'b01) begin
         miscompares++;
         $display("FAIL offturn_turn: got rsp_valid=%b turn=%b expected 0 1", rsp_valid, turn);
      end
   endtask

   task automatic test_first_move();
      apply_reset();
      use_board = 1;
      transact(0, 3'd3, 0, 0, 0, 0, 0);
      vectors++;
      if ({turn, last_rsp[5], last_rsp[4]} !== 3'b100) begin
         miscompares++;
         $display("FAIL first_move: got turn=%b rsp_player=%b err=%b expected 1 0 0", turn, last_rsp[5], last_rsp[4]);
      end
      transact(1, 3'd4, 2, 3, 2, 2, 1);
      transact(0, 3'd3, 0, 1, 0, 1, 1);
   endtask

   task automatic test_column_full();
      int t;
      apply_reset();
      use_board = 1;
      for (int i = 0; i < 6; i++) transact(m_turn, 3'd2, 0, 0, 0, 0, 0);
      t = m_turn;
      transact(t, 3'd2, 1, 0, 1, 0, 1);
      vectors++;
      if ({last_rsp[4], turn} !== {1'b1, 1'(t)}) begin
         miscompares++;
         $display("FAIL column_full: got err=%b turn=%b expected 1 %0d", last_rsp[4], turn, t);
      end
      transact(t, 3'd3, 0, 0, 0, 0, 0);
      vectors++;
      if ({last_rsp[5], last_rsp[4]} !== {1'(t), 1'b0}) begin
         miscompares++;
         $display("FAIL column_retry: got player=%b err=%b expected %0d 0", last_rsp[5], last_rsp[4], t);
      end
   endtask

   task automatic test_fire_vs_timeout();
      apply_reset();
      use_board = 1;
      transact(0, 3'd1, TIMEOUT_CYCLES - 1, 0, 0, 0, 0);
      transact(1, 3'd1, TIMEOUT_CYCLES - 1, 0, 2, 0, 0);
      expect_timeout(3);
      transact(m_turn, 3'd6, 0, 0, 0, 0, 0);
   endtask

   task automatic play_win_game(input int w, input int last_stall);
      int k = 0;
      int wm = 0;
      int mv = 0;
      res_fin = 0;
      while (!res_fin && mv < 10) begin
         if (m_turn == w) begin
            transact(m_turn, 3'd0, 0, 0, 0, (wm == 3) ? last_stall : 0, 0);
            wm++;
         end else begin
            transact(m_turn, (k % 2) ? 3'd3 : 3'd2, 0, 1, 0, 0, 0);
            k++;
         end
         mv++;
      end
   endtask

   task automatic test_win_saturation();
      int exp_w;
      apply_reset();
      use_board = 1;
      for (int g = 0; g < 4; g++) begin
         play_win_game(0, (g == 3) ? 10 : 0);
         exp_w = (g + 1 > 3) ? 3 : g + 1;
         vectors++;
         if ({last_rsp[4], last_rsp[3], last_rsp[2], p0_wins, p1_wins} !== {3'b010, CNT_W'(exp_w), CNT_W'(0)}) begin
            miscompares++;
            $display("FAIL win_game %0d: got err/fin/win=%b p0w=%0d p1w=%0d expected 010 %0d 0",
                     g, {last_rsp[4], last_rsp[3], last_rsp[2]}, p0_wins, p1_wins, exp_w);
         end
         if (g == 0) begin
            vectors++;
            if (turn !== 1'b1) begin
               miscompares++;
               $display("FAIL new_game_turn: got %b expected 1", turn);
            end
         end
      end
   endtask

   task automatic test_random();
      int idle_d;
      apply_reset();
      use_board = 0;
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 9) == 0) expect_timeout($urandom_range(0, 3));
         else begin
            idle_d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TIMEOUT_CYCLES - 1) : 0;
            transact(m_turn, 3'($urandom_range(0, 6)), idle_d, $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         end
      end
   endtask

   task automatic test_reset_after_play();
      set_req(m_turn, 1, 3'd2);
      @(posedge clk); #1;
      @(posedge clk); #3;
      rst_n = 0;
      #1;
      vectors++;
      if ({core_op_valid, core_re_ready, rsp_valid, turn, p0_wins, p1_wins, ties} !== '0) begin
         miscompares++;
         $display("FAIL reset_stats: got op_v=%b re_rdy=%b rsp_v=%b turn=%b p0w=%0d p1w=%0d ties=%0d expected all 0",
                  core_op_valid, core_re_ready, rsp_valid, turn, p0_wins, p1_wins, ties);
      end
      drive_idle();
      @(posedge clk); #1 rst_n = 1;
      model_reset();
      use_board = 1;
      transact(0, 3'd5, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 0;
      drive_idle();
      model_reset();
      use_board = 1;
      last_rsp = '0;
      test_reset();
      test_offturn_timeout();
      test_first_move();
      test_column_full();
      test_fire_vs_timeout();
      test_win_saturation();
      test_random();
      test_reset_after_play();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/connect4_turn_ctrl.md
Name: connect4_turn_ctrl

Overview:
- Turn scheduler and arbiter placed in front of the connect4 game core.
- Accepts drop requests from two independent player ports and forwards only the request of the player whose turn it is. Each request goes to the core's op handshake; the core's result returns on a shared response channel.
- Enforces alternating turns and forfeits a turn on inactivity timeout. Alternates the starting player between games and keeps per-player win and tie statistics.

Parameters:
- TIMEOUT_CYCLES, 1000: idle cycles allowed per turn before forfeit; 0 disables the timeout.
- TO_W, 16: timeout counter width; TIMEOUT_CYCLES must be < 2**TO_W.
- CNT_W, 8: width of the win/tie statistic counters; counters saturate.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- p0_req_valid  in  1  player 0 drop request.
- p0_req_ready  out  1  player 0 request accepted.
- p0_req_col  in  3  player 0 column, 0..6.
- p1_req_valid / p1_req_ready / p1_req_col  in/out/in  1/1/3  same for player 1.
- core_op_ready  in  1  core accepts an operation.
- core_op_valid  out  1  operation to core.
- core_op_player_id  out  1  player of the forwarded operation.
- core_op_col_id  out  3  column of the forwarded operation.
- core_re_ready  out  1  controller accepts the core result.
- core_re_valid  in  1  core result valid.
- core_re_err, core_re_is_finished, core_re_winner, core_re_tie  in  1 each  core result fields.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_player  out  1  player the response belongs to.
- rsp_err, rsp_finished, rsp_winner, rsp_tie  out  1 each  copied from the core result.
- rsp_timeout  out  1  response is a forfeit due to timeout.
- turn  out  1  player currently allowed to move.
- p0_wins, p1_wins, ties  out  CNT_W each  game statistics.

Behaviour:
- All outputs are registered except p0_req_ready and p1_req_ready.
  - px_req_ready = (state==S_IDLE) & (turn==x).
- Reset values:
  - state S_IDLE; turn=0; start_player=0; all counters 0.
  - core_op_valid=0, core_op_player_id=0, core_op_col_id=0, core_re_ready=0.
  - rsp_valid=0 and all rsp_* fields 0.
- Request fire = px_req_valid & px_req_ready. A request from the off-turn player is never accepted; it is held by backpressure. Column range is not checked here; the core reports a full column as an error.
- S_IDLE:
  - On fire: latch player and column; core_op_valid<=1; go to S_ISSUE.
  - Otherwise increment to_cnt. If TIMEOUT_CYCLES!=0 and to_cnt==TIMEOUT_CYCLES-1, go to S_RSP with rsp_valid<=1, rsp_timeout<=1, rsp_player<=turn, other rsp fields 0.
  - If a fire and the timeout occur in the same cycle, the fire wins.
  - to_cnt clears whenever S_IDLE is entered.
- S_ISSUE:
  - core_op_valid is held with stable payload until core_op_valid & core_op_ready.
  - Then core_op_valid<=0, core_re_ready<=1, go to S_WAIT_RE.
- S_WAIT_RE:
  - On core_re_valid & core_re_ready: core_re_ready<=0; capture the result into rsp_*; rsp_timeout<=0; rsp_valid<=1; go to S_RSP.
- S_RSP:
  - rsp_* are held stable until rsp_valid & rsp_ready.
  - On that fire, rsp_valid<=0 and return to S_IDLE, applying exactly one of the following updates:
    - timeout response: turn<=~turn.
    - rsp_err=1: turn unchanged; the same player retries.
    - rsp_finished=1 and rsp_tie=0: increment the winner's wins counter; start_player<=~start_player; turn<=~start_player (new game).
    - rsp_finished=1 and rsp_tie=1: ties+1; start_player and turn updated as for a win.
    - otherwise (normal move): turn<=~turn.
- Statistic counters saturate at 2**CNT_W-1 and never wrap.
- Latency from request fire to rsp_valid = 3 + (core_op_ready stall cycles) + (core result latency), assuming the core has op_ready=1.
- Reset asserted mid-operation returns everything to reset values immediately; any in-flight core operation is abandoned. The core shares rst_n, so its board is cleared consistently.

Test Plan:
- Reset, then p0 requests col 3 -> core sees op_player_id=0, col 3; one response with rsp_player=0, err=0; turn becomes 1.
- After reset, p1_req_valid=1 while turn=0 -> p1_req_ready stays 0 for 50 cycles; no core_op_valid.
- Fill col 2 with 6 alternating moves, then the current player requests col 2 again -> rsp_err=1; turn unchanged; the same player's next request is accepted.
- TIMEOUT_CYCLES=20, no requests after reset -> rsp_valid with rsp_timeout=1, rsp_player=0 exactly 20 cycles after entering S_IDLE; after rsp fire turn=1.
- p0 plays col 0 four times with p1 on col 1 -> rsp_finished=1, rsp_winner=0; p0_wins=1; next game turn=1.
- CNT_W=2: four p0 wins -> p0_wins saturates at 3; hold rsp_ready=0 for 10 cycles -> rsp fields stay stable.
